// File: rtl/cla_add_scheduler_if.sv
//==============================================================================
// cla_add_scheduler_if : requester and response bus of the shared adder scheduler
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

interface cla_add_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int W     = 16,
  parameter int WORDS = 2
);
  localparam int OW  = W * WORDS;
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*OW-1:0] req_a;
  logic [NREQ*OW-1:0] req_b;
  logic [NREQ-1:0]    req_cin;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [OW-1:0]      rsp_sum;
  logic               rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

`default_nettype wire

// File: rtl/cla_add_scheduler.sv
//==============================================================================
// cla_add_scheduler : round-robin sharing of one W-bit adder, multi-word add
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

module cla_add_scheduler #(
  parameter int NREQ  = 4,
  parameter int W     = 16,
  parameter int WORDS = 2
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  cla_add_scheduler_if.slave  bus,
  output logic [W-1:0]        o_add_a,
  output logic [W-1:0]        o_add_b,
  output logic                o_add_cin,
  input  wire logic [W-1:0]   i_add_s,
  input  wire logic           i_add_cout
);
  localparam int OW  = W * WORDS;
  localparam int IDW = $clog2(NREQ);
  localparam int WIW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_last;
  logic [IDW-1:0]  r_id;
  logic [WIW-1:0]  r_idx;
  logic [OW-1:0]   r_a;
  logic [OW-1:0]   r_b;
  logic [OW-1:0]   r_acc;
  logic            r_add_cin;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [OW-1:0]   r_rsp_sum;
  logic            r_rsp_cout;

  logic            w_any;
  logic [IDW-1:0]  w_gidx;
  logic [OW-1:0]   w_sel_a;
  logic [OW-1:0]   w_sel_b;
  logic            w_sel_cin;
  logic [OW-1:0]   w_acc_next;

  // Scan from farthest to nearest so the requester closest after r_last wins.
  always_comb begin
    logic [IDW:0]   j_full;
    logic [IDW-1:0] j;
    w_any  = 1'b0;
    w_gidx = '0;
    j_full = '0;
    j      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j_full = {1'b0, r_last} + (IDW+1)'(k);
      if (j_full >= (IDW+1)'(NREQ))
        j_full = j_full - (IDW+1)'(NREQ);
      j = j_full[IDW-1:0];
      if (bus.req_valid[j]) begin
        w_any  = 1'b1;
        w_gidx = j;
      end
    end
  end

  always_comb begin
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_cin = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_gidx == IDW'(k)) begin
        w_sel_a   = bus.req_a[k*OW +: OW];
        w_sel_b   = bus.req_b[k*OW +: OW];
        w_sel_cin = bus.req_cin[k];
      end
    end
  end

  // Result words enter at the top so word 0 ends at the bottom after WORDS steps.
  generate
    if (WORDS > 1) begin : g_acc_multi
      assign w_acc_next = {i_add_s, r_acc[OW-1:W]};
    end else begin : g_acc_single
      assign w_acc_next = i_add_s;
    end
  endgenerate

  assign bus.req_ready = (rst_n && (r_state == S_IDLE) && w_any)
                       ? (NREQ'(1) << w_gidx) : '0;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_sum   = r_rsp_sum;
  assign bus.rsp_cout  = r_rsp_cout;

  // Operands shift down one word per EXEC cycle and are all-zero outside EXEC.
  assign o_add_a   = r_a[W-1:0];
  assign o_add_b   = r_b[W-1:0];
  assign o_add_cin = r_add_cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= IDW'(NREQ-1);
      r_id        <= '0;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_add_cin   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a       <= w_sel_a;
            r_b       <= w_sel_b;
            r_add_cin <= w_sel_cin;
            r_id      <= w_gidx;
            r_last    <= w_gidx;
            r_idx     <= '0;
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_acc <= w_acc_next;
          r_a   <= r_a >> W;
          r_b   <= r_b >> W;
          if (r_idx == WIW'(WORDS-1)) begin
            r_add_cin   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_sum   <= w_acc_next;
            r_rsp_cout  <= i_add_cout;
            r_state     <= S_RESP;
          end else begin
            r_add_cin <= i_add_cout;
            r_idx     <= r_idx + WIW'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_cla_add_scheduler.sv
//==============================================================================
// tb_cla_add_scheduler : vector table, directed corner cases, random vs model
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cla_add_scheduler;
  localparam int NREQ  = 4;
  localparam int W     = 16;
  localparam int WORDS = 2;
  localparam int OW    = W * WORDS;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] add_a, add_b, add_s;
  logic         add_cin, add_cout;

  int n_chk = 0;
  int n_bad = 0;

  cla_add_scheduler_if #(.NREQ(NREQ), .W(W), .WORDS(WORDS)) bus ();

  cla_add_scheduler #(.NREQ(NREQ), .W(W), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .o_add_a   (add_a),
    .o_add_b   (add_b),
    .o_add_cin (add_cin),
    .i_add_s   (add_s),
    .i_add_cout(add_cout)
  );

  // External adder model
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b, input logic cin);
    bus.req_a[k*OW +: OW] = a;
    bus.req_b[k*OW +: OW] = b;
    bus.req_cin[k]        = cin;
  endtask

  task automatic do_reset();
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int oh2idx(input logic [NREQ-1:0] oh);
    int r;
    r = -1;
    for (int k = 0; k < NREQ; k++)
      if (oh[k]) r = k;
    return r;
  endfunction

  task automatic apply_vec(input vec_t v);
    logic [16:0] lo;
    lo = {1'b0, v.a[15:0]} + {1'b0, v.b[15:0]} + {16'd0, v.cin};
    tick();
    bus.req_valid = '0;
    bus.req_valid[v.id] = 1'b1;
    set_req(v.id, v.a, v.b, v.cin);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("vec_accept", 64'(bus.req_ready), 64'(1) << v.id);
    tick();
    bus.req_valid = '0;
    set_req(v.id, $urandom, $urandom, 1'($urandom));
    @(negedge clk);
    chk("vec_w0_a", 64'(add_a), 64'(v.a[15:0]));
    chk("vec_w0_b", 64'(add_b), 64'(v.b[15:0]));
    chk("vec_w0_cin", 64'(add_cin), 64'(v.cin));
    chk("vec_w0_rspv", 64'(bus.rsp_valid), 64'(0));
    tick();
    @(negedge clk);
    chk("vec_w1_a", 64'(add_a), 64'(v.a[31:16]));
    chk("vec_w1_cin", 64'(add_cin), 64'(lo[16]));
    tick();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("vec_rspv", 64'(bus.rsp_valid), 64'(1));
    chk("vec_sum", 64'(bus.rsp_sum), 64'(v.sum));
    chk("vec_cout", 64'(bus.rsp_cout), 64'(v.cout));
    chk("vec_id", 64'(bus.rsp_id), 64'(v.id));
    chk("vec_idle_adda", 64'(add_a), 64'(0));
    tick();
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("vec_rspv_drop", 64'(bus.rsp_valid), 64'(0));
  endtask

  vec_t vecs[5];
  int   rr_exp[6] = '{0, 1, 3, 0, 1, 3};
  int   got_id[$];
  int   got_c[$];

  // Reference model state (transaction level)
  int          m_last, m_pick, m_tacc, m_id, m_j;
  bit          m_busy, m_rv;
  logic [31:0] m_sum;
  logic        m_cout;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b0;

    vecs[0] = '{2, 32'h0001_FFFF, 32'h0000_0001, 1'b0, 32'h0002_0000, 1'b0};
    vecs[1] = '{0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[2] = '{3, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[3] = '{1, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 32'h0000_0000, 1'b1};
    vecs[4] = '{0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};

    // Reset values, with requests pending to show req_ready is held low
    bus.req_valid = 4'hF;
    tick();
    @(negedge clk);
    chk("rst_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_rspv", 64'(bus.rsp_valid), 64'(0));
    chk("rst_id", 64'(bus.rsp_id), 64'(0));
    chk("rst_sum", 64'(bus.rsp_sum), 64'(0));
    chk("rst_cout", 64'(bus.rsp_cout), 64'(0));
    chk("rst_add", 64'({add_a, add_b, add_cin}), 64'(0));
    bus.req_valid = '0;
    do_reset();

    for (int i = 0; i < 5; i++)
      apply_vec(vecs[i]);

    // Round-robin with 0,1,3 requesting continuously
    do_reset();
    bus.req_valid = 4'b1011;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 40 && got_id.size() < 6; c++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        got_id.push_back(oh2idx(bus.req_ready));
        got_c.push_back(c);
      end
      tick();
    end
    chk("rr_count", 64'(got_id.size()), 64'(6));
    for (int i = 0; i < got_id.size(); i++) begin
      chk("rr_order", 64'(got_id[i]), 64'(rr_exp[i]));
      if (i > 0) chk("rr_spacing", 64'(got_c[i] - got_c[i-1]), 64'(WORDS + 2));
    end
    bus.req_valid = '0;

    // Backpressure with requester 1 waiting
    do_reset();
    tick();
    bus.req_valid = 4'b0001;
    set_req(0, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_accept0", 64'(bus.req_ready), 64'(1));
    tick();
    bus.req_valid = 4'b0010;
    set_req(1, 32'h0000_0003, 32'h0000_0004, 1'b0);
    @(negedge clk);
    chk("bp_exec_ready", 64'(bus.req_ready), 64'(0));
    tick();
    @(negedge clk);
    chk("bp_exec_ready", 64'(bus.req_ready), 64'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("bp_hold_v", 64'(bus.rsp_valid), 64'(1));
      chk("bp_hold_sum", 64'(bus.rsp_sum), 64'h0001_0000);
      chk("bp_hold_id", 64'(bus.rsp_id), 64'(0));
      chk("bp_hold_cout", 64'(bus.rsp_cout), 64'(0));
      chk("bp_hold_ready", 64'(bus.req_ready), 64'(0));
    end
    tick();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_v", 64'(bus.rsp_valid), 64'(1));
    chk("bp_release_ready", 64'(bus.req_ready), 64'(0));
    tick();
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_accept1", 64'(bus.req_ready), 64'(2));
    chk("bp_rspv_low", 64'(bus.rsp_valid), 64'(0));
    bus.req_valid = '0;

    // Reset during the first EXEC cycle
    do_reset();
    tick();
    bus.req_valid = 4'b0010;
    set_req(1, 32'hAAAA_5555, 32'h0000_0001, 1'b0);
    @(negedge clk);
    chk("rx_accept1", 64'(bus.req_ready), 64'(2));
    tick();
    bus.req_valid = '0;
    chk("rx_exec_a", 64'(add_a), 64'h5555);
    rst_n = 1'b0;
    bus.req_valid = 4'b0011;
    set_req(0, 32'h0000_0010, 32'h0000_0020, 1'b0);
    #1;
    chk("rx_async_add", 64'({add_a, add_b, add_cin}), 64'(0));
    chk("rx_async_ready", 64'(bus.req_ready), 64'(0));
    chk("rx_async_rsp", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout}), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rx_first_grant", 64'(bus.req_ready), 64'(1));
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("rx_no_rsp", 64'(bus.rsp_valid), 64'(0));
    tick();
    @(negedge clk);
    chk("rx_no_rsp", 64'(bus.rsp_valid), 64'(0));
    tick();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("rx_rsp_v", 64'(bus.rsp_valid), 64'(1));
    chk("rx_rsp_id", 64'(bus.rsp_id), 64'(0));
    chk("rx_rsp_sum", 64'(bus.rsp_sum), 64'h30);

    // Random traffic against a transaction-level model
    do_reset();
    m_last = NREQ - 1;
    m_busy = 1'b0;
    m_tacc = 0;
    m_id   = 0;
    m_sum  = '0;
    m_cout = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int k = 0; k < NREQ; k++) begin
        if (bus.req_valid[k]) bus.req_valid[k] = ($urandom_range(0, 7) != 0);
        else                  bus.req_valid[k] = ($urandom_range(0, 2) == 0);
      end
      bus.req_a     = {$urandom, $urandom, $urandom, $urandom};
      bus.req_b     = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) bus.req_b[31:0] = ~bus.req_a[31:0];
      bus.req_cin   = NREQ'($urandom);
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      m_pick = -1;
      if (!m_busy) begin
        for (int k = 1; k <= NREQ; k++) begin
          m_j = (m_last + k) % NREQ;
          if (m_pick < 0 && bus.req_valid[m_j]) m_pick = m_j;
        end
      end
      chk("rnd_ready", 64'(bus.req_ready), (m_pick >= 0) ? (64'(1) << m_pick) : 64'(0));
      m_rv = m_busy && (c >= m_tacc + WORDS + 1);
      chk("rnd_rspv", 64'(bus.rsp_valid), 64'(m_rv));
      if (m_rv) begin
        chk("rnd_sum", 64'(bus.rsp_sum), 64'(m_sum));
        chk("rnd_cout", 64'(bus.rsp_cout), 64'(m_cout));
        chk("rnd_id", 64'(bus.rsp_id), 64'(m_id));
        if (bus.rsp_ready) m_busy = 1'b0;
      end
      if (m_pick >= 0) begin
        m_busy = 1'b1;
        m_tacc = c;
        m_last = m_pick;
        m_id   = m_pick;
        {m_cout, m_sum} = {1'b0, bus.req_a[m_pick*OW +: OW]}
                        + {1'b0, bus.req_b[m_pick*OW +: OW]}
                        + {32'd0, bus.req_cin[m_pick]};
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/cla_add_scheduler.md
# cla_add_scheduler

Shares one combinational 16-bit carry-lookahead adder between several requesters and sequences multi-word additions through it. Each request is a WORDS×W-bit add-with-carry, executed low word first, one word per cycle, with the carry chained through a register. The scheduler sits between the requesting units and a single external adder instance. It owns arbitration, operand sequencing and result return.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 16, adder width in bits; must match the attached adder
- WORDS, 2, words per operation; operand width is OW = W*WORDS
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  NREQ  per-requester request
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*OW  operand A; requester k uses slice [k*OW +: OW]
- req_b  in  NREQ*OW  operand B; same slicing as req_a
- req_cin  in  NREQ  carry-in per requester
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumer accept
- rsp_id  out  clog2(NREQ)  index of the requester that owns the result
- rsp_sum  out  OW  (A + B + cin) mod 2^OW
- rsp_cout  out  1  carry out of the top word
- add_a, add_b  out  W  operand word driven to the adder
- add_cin  out  1  adder carry-in
- add_s  in  W  adder sum; combinational from add_a/add_b/add_cin
- add_cout  in  1  adder carry-out

## Operation
- States: IDLE, EXEC, RESP.
- IDLE, no req_valid: stay in IDLE.
- IDLE, any req_valid: grant one requester by round robin.
  - Search starts at (last_grant+1) mod NREQ and wraps from NREQ-1 to 0.
  - req_ready[g] is asserted combinationally that cycle.
  - On the clock edge: latch the operands and the carry-in; store id = g; last_grant <= g; idx <= 0; go to EXEC.
- EXEC: drive add_a/add_b with word idx of the latched operands and add_cin with the carry register.
  - On each edge: result word idx <= add_s; carry <= add_cout.
  - If idx == WORDS-1, go to RESP; otherwise idx <= idx+1.
- RESP: rsp_valid=1; rsp_id, rsp_sum and rsp_cout are stable.
  - rsp_ready=1: go to IDLE.
  - rsp_ready=0: hold all response outputs unchanged.
- req_ready is 0 in EXEC and RESP. No new request is accepted in the same cycle a response is accepted.
- add_a, add_b and add_cin are 0 outside EXEC.
- Requests are not sticky: a requester that drops req_valid before it is granted is never served.
- Requesters that lose arbitration keep req_valid high and are served in later IDLE cycles. A requester wins again only after every other continuously-requesting requester has been served once.

## Timing
- Reset values:
  - Outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, add_a=0, add_b=0, add_cin=0.
  - Internal: state=IDLE, last_grant=NREQ-1, so requester 0 has first priority.
- If the accept handshake is in cycle t:
  - EXEC occupies cycles t+1 .. t+WORDS.
  - rsp_valid first rises in cycle t+WORDS+1.
  - Default parameters: 3 cycles from accept to rsp_valid.
- Minimum spacing between accepts is WORDS+2 cycles (4 with defaults), reached when rsp_ready is held at 1.
- Reset asserted mid-operation:
  - All state and outputs take reset values immediately (asynchronously).
  - The in-flight transaction is discarded; no response is produced.
  - last_grant returns to NREQ-1.
- Changes on req_a/req_b/req_cin after the accept cycle have no effect.
- Carry chain: word 0 uses the latched req_cin; word i uses the add_cout of word i-1. rsp_cout is the add_cout of the top word.

## Test plan
- Single request, defaults:
  - Stimulus: requester 2, A=0x0001FFFF, B=0x00000001, cin=0.
  - Response: accepted in cycle t; rsp_valid in t+3; rsp_sum=0x00020000, rsp_cout=0, rsp_id=2.
- Full overflow:
  - Stimulus: A=0xFFFFFFFF, B=0x00000000, cin=1.
  - Response: rsp_sum=0x00000000, rsp_cout=1; add_cin=1 in both EXEC cycles.
- Round-robin fairness:
  - Stimulus: requesters 0, 1 and 3 hold req_valid continuously; rsp_ready=1.
  - Response: grant order 0,1,3,0,1,3 (wraps from 3 to 0); accepts exactly 4 cycles apart.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles while in RESP; requester 1 is waiting.
  - Response: response outputs are held stable; req_ready stays 0; requester 1 is accepted in the cycle after rsp_ready goes to 1.
- Reset mid-EXEC:
  - Stimulus: assert rst_n=0 during the first EXEC cycle of a request from requester 1.
  - Response: all outputs are 0 immediately; no response appears after release; with requesters 0 and 1 both requesting after reset, requester 0 is granted first.
- Operand change after accept:
  - Stimulus: A=0x1234_5678, B=0x1111_1111, cin=0; change req_a in cycle t+1.
  - Response: rsp_sum=0x2345_6789, rsp_cout=0.
